// File: rtl/recep_pkg.sv
// Shared scan-code constants and parser state encoding for the keyboard
// command parser.
package recep_pkg;

    // Scan codes with a command meaning; every other code is a digit.
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_H     = 8'h33;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_G     = 8'h34;
    localparam logic [7:0] KEY_CLR   = 8'h2D;

    // Frame assembly phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIG   = 2'd1,
        ST_LEVEL = 2'd2,
        ST_GAS   = 2'd3
    } state_t;

endpackage

// File: rtl/byte_timer.sv
// Inter-byte idle timer: counts strobe-free cycles while a frame is open and
// pulses `expired` on the cycle the idle budget runs out. A strobe in that
// same cycle suppresses the pulse and restarts the count. TIMEOUT=0 disables.
module byte_timer
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: cleared by a strobe or outside a frame, saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || kick) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle is the TIMEOUT-th idle cycle when the count already holds TIMEOUT-1.
    assign expired = (TIMEOUT != 0) && run && !kick && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_parser.sv
// Keyboard command parser: assembles digits plus level/gas codes into a
// shadow frame and commits it atomically to the registered status outputs.
// Input handshake: DATO is consumed on every cycle DATO_VALID=1 (no
// backpressure, back-to-back strobes allowed); DATO is ignored otherwise.
module cmd_parser
    import recep_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NDIG    = 2,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_W-1:0]      DATO,
    input  logic                   DATO_VALID,
    output logic [NDIG*DATA_W-1:0] STTEMP,
    output logic                   STPELIGRO,
    output logic                   STALERTA,
    output logic                   STGAS,
    output logic                   GRESET,
    output logic                   FRAME_DONE,
    output logic                   FRAME_ERR,
    output state_t                 DBG_STATE
);
    localparam int IDXW = $clog2(NDIG + 1);

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]        shadow_q [NDIG];
    logic [DATA_W-1:0]        shadow_d [NDIG];
    logic                     has_dig_q, has_dig_d;
    logic                     lvl_stg_q, lvl_stg_d;
    logic                     pel_stg_q, pel_stg_d;
    logic                     al_stg_q, al_stg_d;
    logic                     gas_stg_q, gas_stg_d;
    logic [NDIG*DATA_W-1:0]   temp_q, temp_d;
    logic                     pel_q, pel_d;
    logic                     al_q, al_d;
    logic                     gas_q, gas_d;
    logic                     greset_q, greset_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     commit, abort, leave;
    logic                     tmr_expired;

    logic is_clr, is_enter, is_h, is_p, is_a, is_g, is_dig;

    assign is_clr   = (DATO == DATA_W'(KEY_CLR));
    assign is_enter = (DATO == DATA_W'(KEY_ENTER));
    assign is_h     = (DATO == DATA_W'(KEY_H));
    assign is_p     = (DATO == DATA_W'(KEY_P));
    assign is_a     = (DATO == DATA_W'(KEY_A));
    assign is_g     = (DATO == DATA_W'(KEY_G));
    assign is_dig   = !(is_clr || is_enter || is_h || is_p || is_a || is_g);

    byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .run     (state_q != ST_IDLE),
        .kick    (DATO_VALID),
        .expired (tmr_expired)
    );

    // Next-state, staging and commit logic; CLR beats everything, timeout only without a strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        has_dig_d = has_dig_q;
        lvl_stg_d = lvl_stg_q;
        pel_stg_d = pel_stg_q;
        al_stg_d  = al_stg_q;
        gas_stg_d = gas_stg_q;
        temp_d    = temp_q;
        pel_d     = pel_q;
        al_d      = al_q;
        gas_d     = gas_q;
        greset_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        leave     = 1'b0;

        if (DATO_VALID) begin
            if (is_clr) begin
                temp_d   = '0;
                pel_d    = 1'b0;
                al_d     = 1'b0;
                gas_d    = 1'b0;
                greset_d = 1'b1;
                for (int i = 0; i < NDIG; i++) shadow_d[i] = '0;
                leave    = 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (is_h) begin
                            state_d = ST_LEVEL;
                        end else if (is_dig) begin
                            shadow_d[0] = DATO;
                            cnt_d       = IDXW'(1);
                            has_dig_d   = 1'b1;
                            state_d     = (NDIG == 1) ? ST_LEVEL : ST_DIG;
                        end
                    end
                    ST_DIG: begin
                        if (is_enter) begin
                            abort = 1'b1;
                        end else begin
                            for (int i = 0; i < NDIG; i++) begin
                                if (cnt_q == IDXW'(i)) shadow_d[i] = DATO;
                            end
                            cnt_d = cnt_q + IDXW'(1);
                            if (cnt_d == IDXW'(NDIG)) state_d = ST_LEVEL;
                        end
                    end
                    ST_LEVEL: begin
                        if (is_p) begin
                            lvl_stg_d = 1'b1;
                            pel_stg_d = 1'b1;
                            al_stg_d  = 1'b1;
                            state_d   = ST_GAS;
                        end else if (is_a) begin
                            lvl_stg_d = 1'b1;
                            pel_stg_d = 1'b0;
                            al_stg_d  = 1'b1;
                            state_d   = ST_GAS;
                        end else if (is_enter) begin
                            commit = 1'b1;
                        end
                    end
                    ST_GAS: begin
                        if (is_g) begin
                            gas_stg_d = 1'b1;
                            commit    = 1'b1;
                        end else if (is_h) begin
                            state_d = ST_LEVEL;
                        end else if (is_enter) begin
                            commit = 1'b1;
                        end
                    end
                endcase
            end
        end else if (tmr_expired) begin
            abort = 1'b1;
        end

        if (abort) begin
            err_d = 1'b1;
            leave = 1'b1;
        end

        if (commit) begin
            if (has_dig_q) begin
                for (int i = 0; i < NDIG; i++) temp_d[i*DATA_W +: DATA_W] = shadow_q[i];
            end
            if (lvl_stg_d) begin
                pel_d = pel_stg_d;
                al_d  = al_stg_d;
            end
            gas_d  = gas_q | gas_stg_d;
            done_d = 1'b1;
            leave  = 1'b1;
        end

        if (leave) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            has_dig_d = 1'b0;
            lvl_stg_d = 1'b0;
            pel_stg_d = 1'b0;
            al_stg_d  = 1'b0;
            gas_stg_d = 1'b0;
        end
    end

    // State, shadow frame and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '{default: '0};
            has_dig_q <= 1'b0;
            lvl_stg_q <= 1'b0;
            pel_stg_q <= 1'b0;
            al_stg_q  <= 1'b0;
            gas_stg_q <= 1'b0;
            temp_q    <= '0;
            pel_q     <= 1'b0;
            al_q      <= 1'b0;
            gas_q     <= 1'b0;
            greset_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            has_dig_q <= has_dig_d;
            lvl_stg_q <= lvl_stg_d;
            pel_stg_q <= pel_stg_d;
            al_stg_q  <= al_stg_d;
            gas_stg_q <= gas_stg_d;
            temp_q    <= temp_d;
            pel_q     <= pel_d;
            al_q      <= al_d;
            gas_q     <= gas_d;
            greset_q  <= greset_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign STTEMP     = temp_q;
    assign STPELIGRO  = pel_q;
    assign STALERTA   = al_q;
    assign STGAS      = gas_q;
    assign GRESET     = greset_q;
    assign FRAME_DONE = done_q;
    assign FRAME_ERR  = err_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: directed frames from the test plan followed by random
// scan-code streams, checked against a frame-level reference model.
module tb_cmd_parser;
    import recep_pkg::*;

    localparam int DW = 8;
    localparam int ND = 2;
    localparam int TO = 10;
    localparam int EW = 3 + ND*DW + 3;

    localparam logic [2:0] EV_DONE = 3'b001;
    localparam logic [2:0] EV_ERR  = 3'b010;
    localparam logic [2:0] EV_CLR  = 3'b100;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [DW-1:0]    DATO = '0;
    logic             DATO_VALID = 1'b0;
    logic [ND*DW-1:0] STTEMP;
    logic             STPELIGRO, STALERTA, STGAS, GRESET, FRAME_DONE, FRAME_ERR;
    logic [1:0]       DBG_STATE;

    always #5 CLK = ~CLK;

    cmd_parser #(.DATA_W(DW), .NDIG(ND), .TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATO       (DATO),
        .DATO_VALID (DATO_VALID),
        .STTEMP     (STTEMP),
        .STPELIGRO  (STPELIGRO),
        .STALERTA   (STALERTA),
        .STGAS      (STGAS),
        .GRESET     (GRESET),
        .FRAME_DONE (FRAME_DONE),
        .FRAME_ERR  (FRAME_ERR),
        .DBG_STATE  (DBG_STATE)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: phase 0 idle, 1 collecting digits, 2 awaiting level, 3 awaiting gas.
    int          m_phase = 0;
    int          m_gap   = 0;
    logic [7:0]  m_digs[$];
    bit          m_lvl_set, m_pel_s, m_al_s, m_gas_s;
    logic [ND*DW-1:0] m_temp = '0;
    bit          m_pel = 0, m_al = 0, m_gas = 0;

    function automatic bit is_digit(input logic [7:0] b);
        return !(b inside {KEY_ENTER, KEY_H, KEY_P, KEY_A, KEY_G, KEY_CLR});
    endfunction

    function automatic logic [EW-1:0] ev(input logic [2:0] kind);
        return {kind, m_temp, m_pel, m_al, m_gas};
    endfunction

    task automatic m_leave();
        m_phase = 0;
        m_gap   = 0;
        m_digs.delete();
        m_lvl_set = 0; m_pel_s = 0; m_al_s = 0; m_gas_s = 0;
    endtask

    task automatic m_reset();
        m_temp = '0; m_pel = 0; m_al = 0; m_gas = 0;
        m_leave();
    endtask

    task automatic m_commit();
        if (m_digs.size() == ND) begin
            for (int i = 0; i < ND; i++) m_temp[i*DW +: DW] = m_digs[i];
        end
        if (m_lvl_set) begin
            m_pel = m_pel_s;
            m_al  = m_al_s;
        end
        m_gas = m_gas | m_gas_s;
        exp_q.push_back(ev(EV_DONE));
        m_leave();
    endtask

    task automatic m_byte(input logic [7:0] b);
        m_gap = 0;
        if (b == KEY_CLR) begin
            m_temp = '0; m_pel = 0; m_al = 0; m_gas = 0;
            exp_q.push_back(ev(EV_CLR));
            m_leave();
        end else begin
            case (m_phase)
                0: begin
                    if (b == KEY_H) m_phase = 2;
                    else if (is_digit(b)) begin
                        m_digs.push_back(b);
                        m_phase = (m_digs.size() == ND) ? 2 : 1;
                    end
                end
                1: begin
                    if (b == KEY_ENTER) begin
                        exp_q.push_back(ev(EV_ERR));
                        m_leave();
                    end else begin
                        m_digs.push_back(b);
                        if (m_digs.size() == ND) m_phase = 2;
                    end
                end
                2: begin
                    if (b == KEY_P) begin
                        m_lvl_set = 1; m_pel_s = 1; m_al_s = 1; m_phase = 3;
                    end else if (b == KEY_A) begin
                        m_lvl_set = 1; m_pel_s = 0; m_al_s = 1; m_phase = 3;
                    end else if (b == KEY_ENTER) m_commit();
                end
                default: begin
                    if (b == KEY_G) begin
                        m_gas_s = 1;
                        m_commit();
                    end else if (b == KEY_H) m_phase = 2;
                    else if (b == KEY_ENTER) m_commit();
                end
            endcase
        end
    endtask

    task automatic m_idle();
        if (m_phase != 0) begin
            m_gap++;
            if (m_gap == TO) begin
                exp_q.push_back(ev(EV_ERR));
                m_leave();
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        DATO       = b;
        DATO_VALID = 1'b1;
        m_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            DATO_VALID = 1'b0;
            DATO       = 8'($urandom);
            m_idle();
        end
    endtask

    task automatic check_status(input string tag, input logic [15:0] t,
                                input bit p, input bit a, input bit g);
        check({tag, "_temp"},  32'(STTEMP),    32'(t));
        check({tag, "_pel"},   32'(STPELIGRO), 32'(p));
        check({tag, "_alert"}, 32'(STALERTA),  32'(a));
        check({tag, "_gas"},   32'(STGAS),     32'(g));
    endtask

    // ---------------- monitor ----------------
    // Pops one expected event for every pulse the DUT presents.
    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1 || FRAME_ERR === 1'b1 || GRESET === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got greset/err/done=%b%b%b want none (t=%0t)",
                         GRESET, FRAME_ERR, FRAME_DONE, $time);
            end else begin
                check("event", 32'({GRESET, FRAME_ERR, FRAME_DONE, STTEMP, STPELIGRO, STALERTA, STGAS}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        int         r;

        // Reset state
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_status("reset", 16'h0000, 0, 0, 0);
        check("reset_pulses", 32'({GRESET, FRAME_ERR, FRAME_DONE}), 32'd0);
        check("reset_state", 32'(DBG_STATE), 32'(ST_IDLE));

        // Full frame with danger and gas; nothing visible before the last byte is taken
        send(8'h16); send(8'h1E); send(8'h4D); send(8'h34);
        check("temp_before_commit", 32'(STTEMP), 32'h0);
        idle(1);
        check_status("frame1", 16'h1E16, 1, 1, 1);

        // Level-only frame keeps temperature, gas is sticky
        send(8'h33); send(8'h1C); send(8'h5A);
        idle(1);
        check_status("frame2", 16'h1E16, 0, 1, 1);

        // ENTER while collecting digits aborts
        send(8'h16); send(8'h5A);
        idle(1);
        check("abort_state", 32'(DBG_STATE), 32'(ST_IDLE));
        check_status("abort", 16'h1E16, 0, 1, 1);

        // CLR mid-frame, then a normal frame
        send(8'h16); send(8'h2D);
        idle(1);
        check_status("clear", 16'h0000, 0, 0, 0);
        send(8'h16); send(8'h1E); send(8'h5A);
        idle(1);
        check_status("after_clear", 16'h1E16, 0, 0, 0);

        // Timeout after TO idle cycles
        send(8'h16);
        idle(TO);
        check("before_expiry_state", 32'(DBG_STATE), 32'(ST_DIG));
        idle(1);
        check("after_expiry_state", 32'(DBG_STATE), 32'(ST_IDLE));

        // Strobe exactly at the expiry cycle keeps the frame alive
        send(8'h25);
        idle(TO - 1);
        send(8'h2E);
        idle(1);
        check("strobe_at_expiry_state", 32'(DBG_STATE), 32'(ST_LEVEL));
        send(8'h5A);
        idle(1);
        check_status("late_frame", 16'h2E25, 0, 0, 0);

        // Reset mid-frame
        send(8'h31); send(8'h32); send(8'h4D);
        @(negedge CLK);
        RST        = 1'b1;
        DATO_VALID = 1'b0;
        m_reset();
        @(negedge CLK);
        check_status("mid_reset", 16'h0000, 0, 0, 0);
        check("mid_reset_state", 32'(DBG_STATE), 32'(ST_IDLE));
        RST = 1'b0;

        // Random scan-code streams
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                6:       b = KEY_H;
                7:       b = KEY_P;
                8:       b = KEY_A;
                9:       b = KEY_G;
                10, 11:  b = KEY_ENTER;
                12:      b = KEY_CLR;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (!is_digit(b)) b = 8'h45;
                end
            endcase
            send(b);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(TO - 2, TO + 2));
            else idle($urandom_range(0, 2));
        end

        idle(TO + 3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check_status("final", m_temp, m_pel, m_al, m_gas);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
